servant_wb_arbiter_n: RTL and testbench

// - N-master to 1-slave Wishbone (cyc/ack, no stb) arbiter; successor to the fixed 3-port servant arbiter.
// - Sits between CPU ibus/dbus, debug module and extra bus masters (DMA, boot loader) and one shared RAM/ROM slave.
// - Supports round-robin or fixed-priority arbitration, one registered grant and an optional stall watchdog.

---
 rtl/servant_wb_arbiter_n.sv | 174 +++++++++++++++++
 tb/tb_servant_wb_arbiter_n.sv | 350 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/servant_wb_arbiter_n.sv
// servant_wb_arbiter_n: N-master to 1-slave Wishbone (cyc/ack) arbiter.
// Round-robin or fixed-priority arbitration with a registered one-hot grant.
// One transaction per grant, with at least one idle slave-cycle between grants.
// Optional stall watchdog is enabled by defining SERVANT_ARB_TIMEOUT_EN.
// Ports:
//   i_clk, i_rst                  clock, asynchronous active-high reset
//   i_m_adr/dat/sel/we/cyc        packed master requests (master k at slice k)
//   o_m_rdt, o_m_ack              shared read data, per-master ack
//   o_s_adr/dat/sel/we/cyc        slave request
//   i_s_rdt, i_s_ack              slave response
//   o_grant                       one-hot grant, zero while idle
//   o_timeout                     one-cycle pulse on watchdog abort
module servant_wb_arbiter_n #(
  parameter int unsigned NUM_MASTERS    = 4,
  parameter int unsigned AW             = 32,
  parameter int unsigned DW             = 32,
  parameter int unsigned PRIORITY_MODE  = 0,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                        i_clk,
  input  logic                        i_rst,
  input  logic [NUM_MASTERS*AW-1:0]   i_m_adr,
  input  logic [NUM_MASTERS*DW-1:0]   i_m_dat,
  input  logic [NUM_MASTERS*DW/8-1:0] i_m_sel,
  input  logic [NUM_MASTERS-1:0]      i_m_we,
  input  logic [NUM_MASTERS-1:0]      i_m_cyc,
  output logic [DW-1:0]               o_m_rdt,
  output logic [NUM_MASTERS-1:0]      o_m_ack,
  output logic [AW-1:0]               o_s_adr,
  output logic [DW-1:0]               o_s_dat,
  output logic [DW/8-1:0]             o_s_sel,
  output logic                        o_s_we,
  output logic                        o_s_cyc,
  input  logic [DW-1:0]               i_s_rdt,
  input  logic                        i_s_ack,
  output logic [NUM_MASTERS-1:0]      o_grant,
  output logic                        o_timeout
);

  localparam int unsigned SW = DW / 8;
  localparam int unsigned LW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] BUSY = 1'b1;

  // Reject illegal configurations at elaboration
  if (NUM_MASTERS < 2 || NUM_MASTERS > 8 || TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535)
  begin : g_param_check
    $error("servant_wb_arbiter_n: illegal NUM_MASTERS or TIMEOUT_CYCLES");
  end

  logic [0:0]             state, state_nxt;
  logic [NUM_MASTERS-1:0] grant, grant_nxt;
  logic [LW-1:0]          gidx, gidx_nxt;
  logic [LW-1:0]          last, last_nxt;
  logic [LW-1:0]          win_idx;
  logic                   busy;
  logic                   cyc_g;
  logic                   ack_g;
  logic                   to_abort;

  assign busy  = (state == BUSY);
  // Granted master still requesting; a drop means master abort
  assign cyc_g = busy & (|(i_m_cyc & grant));

`ifdef SERVANT_ARB_TIMEOUT_EN
  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] cnt;

  // Watchdog: zero while idle, so it starts from zero on every BUSY entry
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      cnt <= '0;
    end else if (!busy) begin
      cnt <= '0;
    end else if (!i_s_ack && cnt != CW'(TIMEOUT_CYCLES)) begin
      cnt <= cnt + CW'(1);
    end
  end

  // A real ack in the same cycle takes precedence over the watchdog
  assign to_abort = cyc_g & ~i_s_ack & (cnt == CW'(TIMEOUT_CYCLES));
`else
  assign to_abort = 1'b0;
`endif

  assign ack_g = cyc_g & (i_s_ack | to_abort);

  // Winner selection; the last loop assignment is the one that counts
  always_comb begin
    int unsigned s;
    win_idx = '0;
    s       = 0;
    if (PRIORITY_MODE != 0) begin
      for (int unsigned k = NUM_MASTERS; k > 0; k--) begin
        if (i_m_cyc[k-1]) win_idx = LW'(k - 1);
      end
    end else begin
      // Scan last+NUM_MASTERS down to last+1 so the nearest successor wins
      for (int unsigned k = NUM_MASTERS; k > 0; k--) begin
        s = 32'(last) + k;
        if (s >= NUM_MASTERS) s = s - NUM_MASTERS;
        if (i_m_cyc[s]) win_idx = LW'(s);
      end
    end
  end

  // State register
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state <= IDLE;
      grant <= '0;
      gidx  <= '0;
      last  <= LW'(NUM_MASTERS - 1);
    end else begin
      state <= state_nxt;
      grant <= grant_nxt;
      gidx  <= gidx_nxt;
      last  <= last_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    grant_nxt = grant;
    gidx_nxt  = gidx;
    last_nxt  = last;
    case (state)
      IDLE: begin
        if (|i_m_cyc) begin
          state_nxt = BUSY;
          grant_nxt = NUM_MASTERS'(1) << win_idx;
          gidx_nxt  = win_idx;
        end
      end
      BUSY: begin
        if (!cyc_g || ack_g) begin
          state_nxt = IDLE;
          grant_nxt = '0;
          if (ack_g) last_nxt = gidx;
        end
      end
      default: begin
        state_nxt = IDLE;
        grant_nxt = '0;
      end
    endcase
  end

  // Slave request mux: AND-OR over the one-hot grant, zero when idle
  always_comb begin
    o_s_adr = '0;
    o_s_dat = '0;
    o_s_sel = '0;
    o_s_we  = 1'b0;
    for (int unsigned k = 0; k < NUM_MASTERS; k++) begin
      if (grant[k]) begin
        o_s_adr = o_s_adr | i_m_adr[k*AW +: AW];
        o_s_dat = o_s_dat | i_m_dat[k*DW +: DW];
        o_s_sel = o_s_sel | i_m_sel[k*SW +: SW];
        o_s_we  = o_s_we  | i_m_we[k];
      end
    end
  end

  assign o_s_cyc   = cyc_g & ~to_abort;
  assign o_m_ack   = ack_g ? grant : '0;
  assign o_m_rdt   = (i_rst | to_abort) ? '0 : i_s_rdt;
  assign o_grant   = grant;
  assign o_timeout = to_abort;

endmodule

// File: tb/tb_servant_wb_arbiter_n.sv
// Testbench for servant_wb_arbiter_n: a round-robin and a fixed-priority
// instance share the master inputs; each has its own slave ack. Both are
// compared every cycle against an integer-owner reference model.
module tb_servant_wb_arbiter_n;

  localparam int N  = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = DW / 8;
  localparam int TO = 16;
`ifdef SERVANT_ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [N*AW-1:0] m_adr;
  logic [N*DW-1:0] m_dat;
  logic [N*SW-1:0] m_sel;
  logic [N-1:0]    m_we;
  logic [N-1:0]    m_cyc;
  logic [DW-1:0]   s_rdt;
  logic            s_ack [2];

  logic [DW-1:0]   m_rdt [2];
  logic [N-1:0]    m_ack [2];
  logic [AW-1:0]   s_adr [2];
  logic [DW-1:0]   s_dat [2];
  logic [SW-1:0]   s_sel [2];
  logic            s_we  [2];
  logic            s_cyc [2];
  logic [N-1:0]    grant [2];
  logic            tout  [2];

  servant_wb_arbiter_n #(.NUM_MASTERS(N), .AW(AW), .DW(DW), .PRIORITY_MODE(0), .TIMEOUT_CYCLES(TO)) dut_rr (
    .i_clk(clk), .i_rst(rst),
    .i_m_adr(m_adr), .i_m_dat(m_dat), .i_m_sel(m_sel), .i_m_we(m_we), .i_m_cyc(m_cyc),
    .o_m_rdt(m_rdt[0]), .o_m_ack(m_ack[0]),
    .o_s_adr(s_adr[0]), .o_s_dat(s_dat[0]), .o_s_sel(s_sel[0]), .o_s_we(s_we[0]), .o_s_cyc(s_cyc[0]),
    .i_s_rdt(s_rdt), .i_s_ack(s_ack[0]),
    .o_grant(grant[0]), .o_timeout(tout[0])
  );

  servant_wb_arbiter_n #(.NUM_MASTERS(N), .AW(AW), .DW(DW), .PRIORITY_MODE(1), .TIMEOUT_CYCLES(TO)) dut_fp (
    .i_clk(clk), .i_rst(rst),
    .i_m_adr(m_adr), .i_m_dat(m_dat), .i_m_sel(m_sel), .i_m_we(m_we), .i_m_cyc(m_cyc),
    .o_m_rdt(m_rdt[1]), .o_m_ack(m_ack[1]),
    .o_s_adr(s_adr[1]), .o_s_dat(s_dat[1]), .o_s_sel(s_sel[1]), .o_s_we(s_we[1]), .o_s_cyc(s_cyc[1]),
    .i_s_rdt(s_rdt), .i_s_ack(s_ack[1]),
    .o_grant(grant[1]), .o_timeout(tout[1])
  );

  // Reference model: owning master index (-1 = idle), last winner, busy age
  int own [2];
  int lst [2];
  int cnt [2];
  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      own[d] = -1;
      lst[d] = N - 1;
      cnt[d] = 0;
    end
  endtask

  function automatic bit model_to(input int d);
    bit cg;
    cg = (own[d] >= 0) && m_cyc[own[d]];
    return TO_EN && cg && (cnt[d] == TO) && !s_ack[d];
  endfunction

  task automatic check_models();
    for (int d = 0; d < 2; d++) begin
      logic [N-1:0]  g;
      logic [AW-1:0] ea;
      logic [DW-1:0] ed;
      logic [SW-1:0] es;
      logic          ew;
      bit            cg;
      bit            to;
      string         p;
      p  = (d == 0) ? "rr" : "fp";
      g  = '0;
      ea = '0;
      ed = '0;
      es = '0;
      ew = 1'b0;
      cg = 1'b0;
      if (own[d] >= 0) begin
        g  = N'(1) << own[d];
        ea = m_adr[own[d]*AW +: AW];
        ed = m_dat[own[d]*DW +: DW];
        es = m_sel[own[d]*SW +: SW];
        ew = m_we[own[d]];
        cg = m_cyc[own[d]];
      end
      to = model_to(d);
      chk({p, " grant"}, 64'(grant[d]), 64'(g));
      chk({p, " s_cyc"}, 64'(s_cyc[d]), 64'(cg && !to));
      chk({p, " m_ack"}, 64'(m_ack[d]), (cg && (s_ack[d] || to)) ? 64'(g) : 64'd0);
      chk({p, " m_rdt"}, 64'(m_rdt[d]), (rst || to) ? 64'd0 : 64'(s_rdt));
      chk({p, " s_adr"}, 64'(s_adr[d]), 64'(ea));
      chk({p, " s_dat"}, 64'(s_dat[d]), 64'(ed));
      chk({p, " s_sel"}, 64'(s_sel[d]), 64'(es));
      chk({p, " s_we"},  64'(s_we[d]),  64'(ew));
      chk({p, " timeout"}, 64'(tout[d]), 64'(to));
    end
  endtask

  task automatic model_update();
    if (rst) begin
      model_reset();
      return;
    end
    for (int d = 0; d < 2; d++) begin
      if (own[d] < 0) begin
        if (m_cyc != '0) begin
          if (d == 0) begin
            for (int k = 1; k <= N; k++) begin
              if (m_cyc[(lst[d] + k) % N]) begin
                own[d] = (lst[d] + k) % N;
                break;
              end
            end
          end else begin
            for (int i = 0; i < N; i++) begin
              if (m_cyc[i]) begin
                own[d] = i;
                break;
              end
            end
          end
          cnt[d] = 0;
        end
      end else if (!m_cyc[own[d]]) begin
        own[d] = -1;
      end else if (s_ack[d] || model_to(d)) begin
        lst[d] = own[d];
        own[d] = -1;
      end else begin
        cnt[d]++;
      end
    end
  endtask

  task automatic settle();
    #1;
    if (rst) model_reset();
    check_models();
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
    #1;
  endtask

  typedef struct {
    logic [N-1:0] cyc;
    logic         ack;
    logic [N-1:0] eg;
    logic [N-1:0] ea;
    logic         ec;
  } vec_t;

  vec_t tv [18];

  int m1n;
  int m3n;
  int acks;

  initial begin
    // Round-robin, all requesting, ack on second busy cycle: 0,1,2,3,0,1
    for (int t = 0; t < 6; t++) begin
      logic [N-1:0] gm;
      gm = N'(1) << (t % N);
      tv[3*t+0] = '{cyc: 4'b1111, ack: 1'b0, eg: 4'b0000, ea: 4'b0000, ec: 1'b0};
      tv[3*t+1] = '{cyc: 4'b1111, ack: 1'b0, eg: gm,      ea: 4'b0000, ec: 1'b1};
      tv[3*t+2] = '{cyc: 4'b1111, ack: 1'b1, eg: gm,      ea: gm,      ec: 1'b1};
    end

    rst = 1'b1;
    m_adr = '0; m_dat = '0; m_sel = '0; m_we = '0; m_cyc = '0;
    s_rdt = '0; s_ack[0] = 1'b0; s_ack[1] = 1'b0;
    model_reset();
    #2;
    settle();
    chk("reset grant", 64'(grant[0]), 64'd0);
    tick();
    tick();
    rst = 1'b0;

    // Table: round-robin rotation
    for (int i = 0; i < 18; i++) begin
      m_cyc = tv[i].cyc;
      s_ack[0] = tv[i].ack;
      s_ack[1] = 1'b0;
      settle();
      chk($sformatf("tbl%0d grant", i), 64'(grant[0]), 64'(tv[i].eg));
      chk($sformatf("tbl%0d ack", i),   64'(m_ack[0]), 64'(tv[i].ea));
      chk($sformatf("tbl%0d s_cyc", i), 64'(s_cyc[0]), 64'(tv[i].ec));
      tick();
    end
    m_cyc = '0; s_ack[0] = 1'b0;
    settle(); tick(); settle(); tick();

    // M2 alone, slave acks 3 cycles after s_cyc rises
    m_adr[2*AW +: AW] = 32'h0000_8000;
    m_cyc = 4'b0100;
    for (int i = 0; i < 6; i++) begin
      s_ack[0] = (i == 4);
      s_ack[1] = (i == 4);
      settle();
      chk($sformatf("m2 ack%0d", i), 64'(m_ack[0]), (i == 4) ? 64'h4 : 64'h0);
      if (i == 1) begin
        chk("m2 grant", 64'(grant[0]), 64'h4);
        chk("m2 adr", 64'(s_adr[0]), 64'h8000);
      end
      tick();
    end
    m_cyc = '0; s_ack[0] = 1'b0; s_ack[1] = 1'b0;
    settle(); tick(); settle(); tick();

    // M0 write aborted before ack (late ack ignored); M1 granted next
    m_we = 4'b0001;
    m_cyc = 4'b0011;
    settle(); tick();
    settle();
    chk("abort pre s_cyc", 64'(s_cyc[0]), 64'd1);
    chk("abort pre we", 64'(s_we[0]), 64'd1);
    tick();
    m_cyc = 4'b0010; s_ack[0] = 1'b1; s_ack[1] = 1'b1;
    settle();
    chk("abort s_cyc", 64'(s_cyc[0]), 64'd0);
    chk("abort ack", 64'(m_ack[0]), 64'd0);
    tick();
    s_ack[0] = 1'b0; s_ack[1] = 1'b0;
    settle(); tick();
    s_ack[0] = 1'b1; s_ack[1] = 1'b1;
    settle();
    chk("abort next grant", 64'(grant[0]), 64'h2);
    chk("abort next ack", 64'(m_ack[0]), 64'h2);
    tick();
    m_cyc = '0; m_we = '0; s_ack[0] = 1'b0; s_ack[1] = 1'b0;
    settle(); tick();

    // Reset asserted mid-BUSY takes effect without a clock edge
    m_cyc = 4'b1111;
    settle(); tick();
    s_ack[0] = 1'b0;
    settle();
    chk("pre-rst s_cyc", 64'(s_cyc[0]), 64'd1);
    s_ack[0] = 1'b1;
    rst = 1'b1;
    settle();
    chk("rst s_cyc", 64'(s_cyc[0]), 64'd0);
    chk("rst grant", 64'(grant[0]), 64'd0);
    chk("rst ack", 64'(m_ack[0]), 64'd0);
    tick();
    rst = 1'b0; s_ack[0] = 1'b0;
    settle(); tick();
    settle();
    chk("post-rst rr grant", 64'(grant[0]), 64'h1);
    chk("post-rst fp grant", 64'(grant[1]), 64'h1);
    tick();

    // Fixed priority: M1 and M3 continuously, slave acks every busy cycle
    m_cyc = 4'b1010;
    m1n = 0; m3n = 0;
    for (int i = 0; i < 40; i++) begin
      s_ack[0] = (own[0] >= 0);
      s_ack[1] = (own[1] >= 0);
      settle();
      if (m_ack[1][1]) m1n++;
      if (m_ack[1][3]) m3n++;
      tick();
    end
    chk("fp m3 starved", 64'(m3n), 64'd0);
    chk("fp m1 served", 64'(m1n >= 15), 64'd1);
    m_cyc = 4'b1000;
    for (int i = 0; i < 4; i++) begin
      s_ack[0] = (own[0] >= 0);
      s_ack[1] = (own[1] >= 0);
      settle();
      if (m_ack[1][3]) m3n++;
      tick();
    end
    chk("fp m3 after drop", 64'(m3n > 0), 64'd1);
    m_cyc = '0; s_ack[0] = 1'b0; s_ack[1] = 1'b0;
    settle(); tick(); settle(); tick();

    // Watchdog: slave never acks
    s_rdt = 32'hDEAD_BEEF;
    m_cyc = 4'b0001;
`ifdef SERVANT_ARB_TIMEOUT_EN
    for (int i = 0; i < 18; i++) begin
      settle();
      chk($sformatf("to ack%0d", i), 64'(m_ack[0]), (i == 17) ? 64'h1 : 64'h0);
      chk($sformatf("to pulse%0d", i), 64'(tout[0]), 64'(i == 17));
      if (i == 17) chk("to rdt", 64'(m_rdt[0]), 64'd0);
      tick();
    end
`else
    acks = 0;
    for (int i = 0; i < 1000; i++) begin
      settle();
      if (m_ack[0] != '0 || tout[0]) acks++;
      tick();
    end
    chk("no-timeout acks", 64'(acks), 64'd0);
`endif
    m_cyc = '0;
    settle(); tick(); settle(); tick();

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      for (int k = 0; k < N; k++) begin
        if ($urandom_range(3) == 0) m_cyc[k] = ~m_cyc[k];
      end
      m_adr = {$urandom, $urandom, $urandom, $urandom};
      m_dat = {$urandom, $urandom, $urandom, $urandom};
      m_sel = N*SW'($urandom);
      m_we  = N'($urandom);
      s_rdt = $urandom;
      s_ack[0] = ($urandom_range(2) == 0);
      s_ack[1] = ($urandom_range(2) == 0);
      rst = ($urandom_range(249) == 0);
      settle();
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
